instr_fetch_ctrl: RTL and testbench

- Fetch-side request controller feeding the prefetch FIFO.
- Issues word-aligned instruction fetch transactions on an OBI-style split request/response bus.
- Tracks outstanding transactions and throttles so every accepted response has a FIFO slot.
- Pushes responses into the FIFO; on a branch, flushes the FIFO and discards in-flight responses that belong to the old stream.

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared types for the instruction fetch path.
//   - fetch_state_e    : request controller state (IDLE / RUN)
//   - fifo_entry_t     : one prefetch FIFO word {err, rdata}
//   - FETCH_WORD_BYTES : bytes per fetched instruction word
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } fifo_entry_t;

    localparam int unsigned FETCH_WORD_BYTES = 4;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Fetch-side request controller in front of the prefetch FIFO. Issues
//   word-aligned fetches on a split request/response bus, limits outstanding
//   transactions so that every response is guaranteed a FIFO slot, pushes
//   responses into the FIFO and, on a branch, flushes the FIFO and drops the
//   responses still in flight for the old instruction stream.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_i                 fetch enable (in-flight transactions still drain)
//   branch_i              single-cycle redirect strobe
//   branch_addr_i         redirect target, bits [1:0] ignored
//   busy_o                request pending or transactions outstanding
//   trans_valid_o/ready_i request handshake, trans_addr_o word address
//   resp_valid_i          in-order response strobe, one per accepted request
//   resp_rdata_i/err_i    response data and bus error flag
//   fifo_cnt_i            current FIFO occupancy
//   fifo_push_o/data_o    FIFO write strobe and {err, rdata}
//   fifo_flush_o          FIFO flush strobe (equals branch_i)
//   state_dbg_o           current controller state, for observation only
//
// Handshake: a request transfers on a cycle where trans_valid_o and
// trans_ready_i are both high. Once trans_valid_o is raised it stays high
// with a stable trans_addr_o until accepted; only a branch_i cycle may
// retarget the address of a pending request.
// -----------------------------------------------------------------------------
module instr_fetch_ctrl
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PEND  = 2,
    parameter int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) + 1 : 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    output logic             busy_o,
    output logic             trans_valid_o,
    input  logic             trans_ready_i,
    output logic [31:0]      trans_addr_o,
    input  logic             resp_valid_i,
    input  logic [31:0]      resp_rdata_i,
    input  logic             resp_err_i,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    output logic             fifo_push_o,
    output logic [32:0]      fifo_data_o,
    output logic             fifo_flush_o,
    output fetch_state_e     state_dbg_o
);

    localparam int unsigned PCNT_W = (PEND > 0) ? $clog2(PEND + 1) : 1;

    fetch_state_e      state_q, state_d;
    logic [31:2]       addr_q, addr_d;
    logic [PCNT_W-1:0] cnt_q, cnt_d;
    logic [PCNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [31:2]       tgt;
    logic [31:0]       slots_used;
    logic              room;
    logic              below_pend;
    logic              accept;
    fifo_entry_t       entry;

    // Slots already claimed in the FIFO: live (non-flushed) outstanding
    // requests plus words already stored. cnt_q >= flush_cnt_q always holds.
    assign slots_used = 32'(cnt_q) - 32'(flush_cnt_q) + 32'(fifo_cnt_i);
    assign below_pend = 32'(cnt_q) < PEND;

    always_comb begin
        tgt           = branch_i ? branch_addr_i[31:2] : addr_q;
        // A branch flushes the FIFO and orphans every in-flight response,
        // so the whole FIFO is available to the new stream.
        room          = branch_i | (slots_used < DEPTH);
        trans_valid_o = (req_i | branch_i) & ((state_q == RUN) | branch_i)
                        & room & below_pend;
        trans_addr_o  = {tgt, 2'b00};
        accept        = trans_valid_o & trans_ready_i;
        busy_o        = trans_valid_o | (cnt_q != '0);
        fifo_flush_o  = branch_i;
        fifo_push_o   = resp_valid_i & ~branch_i & (flush_cnt_q == '0);
        entry.err     = resp_err_i;
        entry.rdata   = resp_rdata_i;
        fifo_data_o   = entry;
        state_dbg_o   = state_q;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            IDLE:    if (branch_i || req_i) state_d = RUN;
            RUN:     if (!req_i && !branch_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Address wraps naturally within the 30-bit word address.
        if (accept) begin
            addr_d = tgt + 30'd1;
        end else if (branch_i) begin
            addr_d = branch_addr_i[31:2];
        end

        if (accept && !resp_valid_i) begin
            cnt_d = cnt_q + PCNT_W'(1);
        end else if (!accept && resp_valid_i) begin
            cnt_d = cnt_q - PCNT_W'(1);
        end

        // Everything outstanding before the branch is stale, except a
        // response arriving in the branch cycle, which is dropped directly.
        // A request accepted in the branch cycle belongs to the new stream.
        if (branch_i) begin
            flush_cnt_d = cnt_q - PCNT_W'(resp_valid_i);
        end else if (resp_valid_i && (flush_cnt_q != '0)) begin
            flush_cnt_d = flush_cnt_q - PCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    a_resp_without_request: assert property (
        @(posedge clk_i) disable iff (!rst_ni) resp_valid_i |-> (cnt_q != '0));

    a_push_into_full_fifo: assert property (
        @(posedge clk_i) disable iff (!rst_ni) fifo_push_o |-> (32'(fifo_cnt_i) != DEPTH));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
    import instr_fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PEND  = 2;
    localparam int unsigned CNT_W = 3;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic             req_i, branch_i, trans_ready_i;
    logic [31:0]      branch_addr_i, resp_rdata_i;
    logic             resp_valid_i, resp_err_i;
    logic [CNT_W-1:0] fifo_cnt_i;
    logic             busy_o, trans_valid_o, fifo_push_o, fifo_flush_o;
    logic [31:0]      trans_addr_o;
    logic [32:0]      fifo_data_o;
    fetch_state_e     state_dbg_o;

    instr_fetch_ctrl #(.DEPTH(DEPTH), .PEND(PEND)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .busy_o        (busy_o),
        .trans_valid_o (trans_valid_o),
        .trans_ready_i (trans_ready_i),
        .trans_addr_o  (trans_addr_o),
        .resp_valid_i  (resp_valid_i),
        .resp_rdata_i  (resp_rdata_i),
        .resp_err_i    (resp_err_i),
        .fifo_cnt_i    (fifo_cnt_i),
        .fifo_push_o   (fifo_push_o),
        .fifo_data_o   (fifo_data_o),
        .fifo_flush_o  (fifo_flush_o),
        .state_dbg_o   (state_dbg_o)
    );

    // ---------------- reference model ----------------
    // In-flight requests in issue order; 1 marks a request of an abandoned
    // stream whose response must be discarded.
    bit          stale_q[$];
    bit          running;
    logic [29:0] m_addr;
    int          occ;
    bit          hold_req;
    logic [32:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stale_q.delete();
        exp_q.delete();
        running  = 1'b0;
        m_addr   = '0;
        occ      = 0;
        hold_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni        = 1'b0;
        req_i         = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        trans_ready_i = 1'b0;
        resp_valid_i  = 1'b0;
        resp_rdata_i  = '0;
        resp_err_i    = 1'b0;
        fifo_cnt_i    = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rst_valid", trans_valid_o, 0);
        check("rst_push",  fifo_push_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_state", state_dbg_o, IDLE);
    endtask

    // One bus cycle: drive inputs, compare against the model, advance model.
    task automatic do_cycle(input bit req, input bit br, input logic [31:0] baddr,
                            input bit rdy, input bit rv, input logic [31:0] rdata,
                            input bit err, input bit pop);
        int          live;
        bit          exp_valid, exp_push, acc, front;
        logic [29:0] tgt;
        logic [32:0] exp_data;
        @(negedge clk_i);
        if (stale_q.size() == 0) rv = 1'b0;
        if (hold_req) req = 1'b1;
        req_i         = req;
        branch_i      = br;
        branch_addr_i = baddr;
        trans_ready_i = rdy;
        resp_valid_i  = rv;
        resp_rdata_i  = rdata;
        resp_err_i    = err;
        fifo_cnt_i    = CNT_W'(occ);
        #1;
        live = 0;
        foreach (stale_q[i]) if (!stale_q[i]) live++;
        exp_valid = (req || br) && (running || br) && (br || (live + occ < DEPTH))
                    && (stale_q.size() < PEND);
        tgt      = br ? baddr[31:2] : m_addr;
        front    = rv ? stale_q[0] : 1'b0;
        exp_push = rv && !br && !front;

        check("state", state_dbg_o, running ? RUN : IDLE);
        check("valid", trans_valid_o, exp_valid);
        if (exp_valid) check("addr", trans_addr_o, {tgt, 2'b00});
        check("push",  fifo_push_o, exp_push);
        if (exp_push) begin
            exp_q.push_back({err, rdata});
            exp_data = exp_q.pop_front();
            check("data", fifo_data_o, exp_data);
        end
        check("flush", fifo_flush_o, br);
        check("busy",  busy_o, exp_valid || (stale_q.size() != 0));

        acc = exp_valid && rdy;
        if (rv) front = stale_q.pop_front();
        if (br) foreach (stale_q[i]) stale_q[i] = 1'b1;
        if (acc) stale_q.push_back(1'b0);
        if (acc) m_addr = tgt + 30'd1;
        else if (br) m_addr = baddr[31:2];
        if (br) running = 1'b1;
        else if (running && !req) running = 1'b0;
        else if (!running && req) running = 1'b1;
        if (br) occ = 0;
        else begin
            if (pop && occ > 0) occ--;
            if (exp_push) occ++;
        end
        hold_req = exp_valid && !rdy;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst_ni = 1'b0;
        apply_reset();

        // Fetch enable alone out of reset: idle this cycle, no request.
        do_cycle(1, 0, 32'h0, 1, 0, 0, 0, 0);
        do_cycle(0, 0, 32'h0, 1, 0, 0, 0, 0);
        do_cycle(0, 0, 32'h0, 1, 1, 0, 0, 0);

        // Branch to 0x1002 then stream with responses one cycle behind.
        do_cycle(1, 1, 32'h0000_1002, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            do_cycle(1, 0, 32'h0, 1, 1, 32'hA000_0000 + i, 0, 1);
        do_cycle(0, 0, 32'h0, 1, 1, 32'hA0, 0, 1);
        do_cycle(0, 0, 32'h0, 1, 1, 32'hA1, 0, 1);

        // No responses: PEND caps outstanding requests, a response re-opens.
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 32'h0, 1, 0, 0, 0, 0);
        do_cycle(1, 0, 32'h0, 1, 1, 32'hB0, 0, 0);
        do_cycle(1, 0, 32'h0, 1, 0, 0, 0, 0);

        // FIFO fills without popping: room check throttles, pops release.
        for (int i = 0; i < 6; i++) do_cycle(1, 0, 32'h0, 1, 1, 32'hC0 + i, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(1, 0, 32'h0, 1, 1, 32'hC8 + i, 0, 1);

        // Two outstanding, branch with a same-cycle response.
        do_cycle(1, 0, 32'h0, 1, 0, 0, 0, 1);
        do_cycle(1, 0, 32'h0, 1, 0, 0, 0, 1);
        do_cycle(1, 1, 32'h0000_2000, 1, 1, 32'hD0, 0, 1);
        do_cycle(1, 0, 32'h0, 0, 1, 32'hD1, 0, 1);
        do_cycle(1, 0, 32'h0, 0, 1, 32'hD2, 0, 1);
        do_cycle(0, 0, 32'h0, 0, 1, 32'hD3, 0, 1);

        // Wrap at the top of the address space and error responses.
        do_cycle(1, 1, 32'hFFFF_FFFC, 1, 1, 32'hE0, 0, 1);
        do_cycle(1, 0, 32'h0, 1, 1, 32'hE1, 1, 1);
        do_cycle(1, 0, 32'h0, 1, 1, 32'hE2, 1, 1);
        do_cycle(1, 0, 32'h0, 1, 1, 32'hE3, 0, 1);

        // Reset with transactions outstanding.
        apply_reset();

        for (int n = 0; n < 3000; n++) begin
            do_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, $urandom,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            if (n == 1500) apply_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
